// File: rtl/booth_mac_accum.sv
// Streaming saturating accumulator behind the Booth multiplier: sums TERMS signed
// products, then holds the dot-product result until the consumer takes it.
module booth_mac_accum #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int TERMS  = 4,
  localparam int CNT_W = $clog2(TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              clear,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_sat,
  output logic [CNT_W-1:0]  term_cnt
);

  // Handshake rule for both ports: a beat transfers on a rising edge where
  // valid && ready are both high; prod_data is only looked at on that beat.

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [ACC_W:0]   sum_ext;
  logic             ovf_pos;
  logic             ovf_neg;
  logic [ACC_W-1:0] acc_clamped;
  logic             accept;

  // clear wins over a concurrent product by withdrawing ready.
  assign prod_ready = (state_q == ST_ACCUM) && !clear;
  assign accept     = prod_valid && prod_ready;

  // One guard bit is enough: the two top bits disagree exactly on overflow.
  assign sum_ext = {acc_q[ACC_W-1], acc_q}
                 + {{(ACC_W + 1 - PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign ovf_pos = (sum_ext[ACC_W:ACC_W-1] == 2'b01);
  assign ovf_neg = (sum_ext[ACC_W:ACC_W-1] == 2'b10);

  always_comb begin
    acc_clamped = sum_ext[ACC_W-1:0];
    if (ovf_pos) acc_clamped = ACC_MAX;
    if (ovf_neg) acc_clamped = ACC_MIN;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clear) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            acc_d = acc_clamped;
            sat_d = sat_q | ovf_pos | ovf_neg;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // res_valid is the FSM state itself, so the state is visible at the boundary.
  assign res_valid = (state_q == ST_HOLD);
  assign res_data  = acc_q;
  assign res_sat   = sat_q;
  assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Bench for booth_mac_accum: directed steps plus random traffic on the default
// instance against an integer model, and saturation steps on a 9-bit instance.
module tb_booth_mac_accum;

  localparam int TERMS = 4;
  localparam int ACC_W = 16;
  localparam int MAXV  = (1 << (ACC_W - 1)) - 1;
  localparam int MINV  = -(1 << (ACC_W - 1));

  logic        clk = 1'b0;
  logic        rst;
  logic        prod_valid, prod_ready, clear, res_valid, res_ready, res_sat;
  logic [7:0]  prod_data;
  logic [15:0] res_data;
  logic [2:0]  term_cnt;

  logic        b_prod_valid, b_prod_ready, b_clear, b_res_valid, b_res_ready, b_res_sat;
  logic [7:0]  b_prod_data;
  logic [8:0]  b_res_data;
  logic [2:0]  b_term_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // model of the default instance
  int          m_acc  = 0;
  int          m_cnt  = 0;
  logic        m_sat  = 1'b0;
  logic        m_hold = 1'b0;
  logic [ACC_W:0] exp_q[$];

  booth_mac_accum dut (
    .clk(clk), .rst(rst),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .clear(clear),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_sat(res_sat), .term_cnt(term_cnt)
  );

  booth_mac_accum #(.ACC_W(9)) dut9 (
    .clk(clk), .rst(rst),
    .prod_valid(b_prod_valid), .prod_ready(b_prod_ready), .prod_data(b_prod_data),
    .clear(b_clear),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_data(b_res_data),
    .res_sat(b_res_sat), .term_cnt(b_term_cnt)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_feed(input logic [7:0] d);
    prod_valid = 1'b1;
    prod_data  = d;
    cyc();
  endtask

  task automatic a_take();
    prod_valid = 1'b0;
    res_ready  = 1'b1;
    cyc();
    res_ready  = 1'b0;
  endtask

  task automatic b_sum(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [7:0] d3, input logic [8:0] exp_d, input logic exp_s,
                       input string tag);
    logic [7:0] d[4];
    d = '{d0, d1, d2, d3};
    b_prod_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_prod_data = d[i];
      cyc();
    end
    b_prod_valid = 1'b0;
    check({tag, "_valid"}, b_res_valid, 1'b1);
    check({tag, "_data"}, b_res_data, exp_d);
    check({tag, "_sat"}, b_res_sat, exp_s);
    b_res_ready = 1'b1;
    cyc();
    b_res_ready = 1'b0;
    check({tag, "_taken"}, b_res_valid, 1'b0);
    check({tag, "_satclr"}, b_res_sat, 1'b0);
  endtask

  // scoreboard: compare against the model, then advance the model by the cycle's inputs
  always @(negedge clk) begin
    if (!rst) begin
      check("mon_res_valid", res_valid, m_hold);
      check("mon_term_cnt", term_cnt, 32'(m_cnt));
      check("mon_res_sat", res_sat, m_sat);
      check("mon_prod_ready", prod_ready, !m_hold && !clear);
    end
    if (rst || clear) begin
      exp_q.delete();
      m_acc = 0; m_cnt = 0; m_sat = 1'b0; m_hold = 1'b0;
    end else if (m_hold) begin
      if (res_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          check("sb_result", {res_sat, res_data}, exp_q.pop_front());
        end
        m_acc = 0; m_cnt = 0; m_sat = 1'b0; m_hold = 1'b0;
      end
    end else if (prod_valid) begin
      m_acc = m_acc + int'($signed(prod_data));
      if (m_acc > MAXV) begin m_acc = MAXV; m_sat = 1'b1; end
      if (m_acc < MINV) begin m_acc = MINV; m_sat = 1'b1; end
      m_cnt++;
      if (m_cnt == TERMS) begin
        m_hold = 1'b1;
        exp_q.push_back({m_sat, ACC_W'(m_acc)});
      end
    end
  end

  initial begin
    rst = 1'b1;
    prod_valid = 1'b0; prod_data = '0; clear = 1'b0; res_ready = 1'b0;
    b_prod_valid = 1'b0; b_prod_data = '0; b_clear = 1'b0; b_res_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 16'h0000);
    check("rst_res_sat", res_sat, 1'b0);
    check("rst_term_cnt", term_cnt, 3'd0);
    check("rst_prod_ready", prod_ready, 1'b1);

    // basic sum: 3 - 5 + 7 - 1
    a_feed(8'd3); a_feed(8'hFB); a_feed(8'd7); a_feed(8'hFF);
    prod_valid = 1'b0;
    check("basic_valid", res_valid, 1'b1);
    check("basic_data", res_data, 16'h0004);
    check("basic_sat", res_sat, 1'b0);
    check("basic_cnt", term_cnt, 3'd4);
    a_take();
    check("basic_taken", res_valid, 1'b0);

    // backpressure with a product waiting
    a_feed(8'd1); a_feed(8'd2); a_feed(8'd3); a_feed(8'd4);
    prod_data = 8'd5;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_low", prod_ready, 1'b0);
      check("bp_data_stable", res_data, 16'd10);
      check("bp_cnt_stable", term_cnt, 3'd4);
      cyc();
    end
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    check("bp_handoff_cnt", term_cnt, 3'd0);
    check("bp_handoff_valid", res_valid, 1'b0);
    cyc();
    check("bp_first_accept", term_cnt, 3'd1);
    a_feed(8'd6); a_feed(8'd7); a_feed(8'd8);
    check("bp_next_sum", res_data, 16'd26);
    a_take();

    // clear mid-sum beats a concurrent product
    a_feed(8'd10); a_feed(8'd20);
    prod_data = 8'd30;
    clear = 1'b1;
    #1;
    check("clr_ready_low", prod_ready, 1'b0);
    cyc();
    clear = 1'b0;
    check("clr_cnt", term_cnt, 3'd0);
    a_feed(8'd1); a_feed(8'd2); a_feed(8'd3); a_feed(8'd4);
    check("clr_sum", res_data, 16'd10);
    a_take();

    // clear in HOLD drops the result even with res_ready high
    a_feed(8'd1); a_feed(8'd1); a_feed(8'd1); a_feed(8'd1);
    prod_valid = 1'b0;
    clear = 1'b1; res_ready = 1'b1;
    cyc();
    clear = 1'b0; res_ready = 1'b0;
    check("clrhold_valid", res_valid, 1'b0);
    check("clrhold_cnt", term_cnt, 3'd0);
    check("clrhold_sat", res_sat, 1'b0);

    // reset mid-operation
    a_feed(8'd5); a_feed(8'd6);
    rst = 1'b1;
    prod_data = 8'd7;
    cyc();
    rst = 1'b0;
    check("midrst_cnt", term_cnt, 3'd0);
    check("midrst_valid", res_valid, 1'b0);
    check("midrst_data", res_data, 16'h0000);
    check("midrst_sat", res_sat, 1'b0);
    a_feed(8'd7); a_feed(8'd8); a_feed(8'd9); a_feed(8'd10);
    check("midrst_sum", res_data, 16'd34);
    a_take();

    // saturation on the 9-bit accumulator
    b_sum(8'd127, 8'd127, 8'd127, 8'd127, 9'h0FF, 1'b1, "sat_pos");
    b_sum(8'h80, 8'h80, 8'h80, 8'h80, 9'h100, 1'b1, "sat_neg");
    b_sum(8'd127, 8'd127, 8'd127, 8'h9C, 9'd155, 1'b1, "sat_then_add");
    b_sum(8'd50, 8'hE2, 8'd10, 8'd1, 9'd31, 1'b0, "nosat_mix");

    // random traffic on the default instance, checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      prod_valid = ($urandom_range(0, 3) != 0);
      prod_data  = 8'($urandom_range(0, 255));
      res_ready  = 1'($urandom_range(0, 1));
      clear      = ($urandom_range(0, 15) == 0);
      cyc();
    end
    clear = 1'b0;
    a_take();
    a_take();
    check("final_idle", res_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
